// File: rtl/ssd_scan_decoder_if.sv
// Bus bundle for the seven-segment scan decoder: sampled display inputs
// (driven by the master) and decoded results (driven by the decoder).
interface ssd_scan_decoder_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  sample_en;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic [4*DIGITS-1:0]   digits_out;
  logic [DIGITS-1:0]     digit_valid;
  logic                  frame_valid;
  logic                  err;
  logic [IW-1:0]         err_digit;

  modport master (
    output sample_en, an, seg,
    input  digits_out, digit_valid, frame_valid, err, err_digit
  );

  modport slave (
    input  sample_en, an, seg,
    output digits_out, digit_valid, frame_valid, err, err_digit
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit
// pattern and decodes stable patterns back to hex nibbles with frame/error flags.
module ssd_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  ssd_scan_decoder_if.slave bus
);
  localparam int         IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] STABLE_C = STABLE_CNT[3:0];

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HELD = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         cidx_q, cidx_d;
  logic [6:0]            cseg_q, cseg_d;
  logic [4*DIGITS-1:0]   digits_q, digits_d;
  logic [DIGITS-1:0]     valid_q, valid_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic                  frame_q, frame_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         err_digit_q, err_digit_d;

  logic [7:0]            zeros_s;
  logic [IW-1:0]         idx_s;
  logic                  match_s;
  logic                  start_s;
  logic                  commit_s;
  logic [5:0]            dec_s;
  logic [DIGITS-1:0]     mask_s;

  // Returns {legal, blank, nibble} for an active-low segment code.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40:   decode_seg = {2'b10, 4'h0};
      7'h79:   decode_seg = {2'b10, 4'h1};
      7'h24:   decode_seg = {2'b10, 4'h2};
      7'h30:   decode_seg = {2'b10, 4'h3};
      7'h19:   decode_seg = {2'b10, 4'h4};
      7'h12:   decode_seg = {2'b10, 4'h5};
      7'h02:   decode_seg = {2'b10, 4'h6};
      7'h78:   decode_seg = {2'b10, 4'h7};
      7'h00:   decode_seg = {2'b10, 4'h8};
      7'h10:   decode_seg = {2'b10, 4'h9};
      7'h08:   decode_seg = {2'b10, 4'hA};
      7'h03:   decode_seg = {2'b10, 4'hB};
      7'h46:   decode_seg = {2'b10, 4'hC};
      7'h21:   decode_seg = {2'b10, 4'hD};
      7'h06:   decode_seg = {2'b10, 4'hE};
      7'h0E:   decode_seg = {2'b10, 4'hF};
      7'h7F:   decode_seg = {2'b01, 4'h0};
      default: decode_seg = {2'b00, 4'h0};
    endcase
  endfunction

  // Count low enables and locate the selected digit.
  always_comb begin
    zeros_s = 8'd0;
    idx_s   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bus.an[i]) begin
        zeros_s = zeros_s + 8'd1;
        idx_s   = IW'(i);
      end else begin
        zeros_s = zeros_s;
      end
    end
  end

  // Debounce FSM, commit decode and frame/error generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cidx_d      = cidx_q;
    cseg_d      = cseg_q;
    digits_d    = digits_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    frame_d     = 1'b0;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;
    start_s     = 1'b0;
    commit_s    = 1'b0;
    match_s     = (idx_s == cidx_q) && (bus.seg == cseg_q);
    dec_s       = decode_seg(bus.seg);
    mask_s      = seen_q;

    if (!bus.sample_en) begin
      state_d = state_q;
    end else if (zeros_s == 8'd0) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (zeros_s > 8'd1) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE:  start_s = 1'b1;
        TRACK: begin
          if (!match_s) begin
            start_s = 1'b1;
          end else if (cnt_q + 4'd1 >= STABLE_C) begin
            cnt_d    = STABLE_C;
            commit_s = 1'b1;
            state_d  = HELD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        HELD: begin
          if (!match_s) begin
            start_s = 1'b1;
          end else begin
            state_d = HELD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      if (start_s) begin
        cidx_d = idx_s;
        cseg_d = bus.seg;
        cnt_d  = 4'd1;
        if (STABLE_CNT == 1) begin
          commit_s = 1'b1;
          state_d  = HELD;
        end else begin
          state_d = TRACK;
        end
      end else begin
        cidx_d = cidx_q;
      end
    end

    // The committed pattern always equals the live segment bus this cycle.
    if (commit_s) begin
      if (dec_s[5]) begin
        digits_d[{idx_s, 2'b00} +: 4] = dec_s[3:0];
        valid_d[idx_s]                = 1'b1;
      end else if (dec_s[4]) begin
        digits_d[{idx_s, 2'b00} +: 4] = 4'h0;
        valid_d[idx_s]                = 1'b0;
      end else begin
        valid_d[idx_s] = 1'b0;
        err_d          = 1'b1;
        err_digit_d    = idx_s;
      end
      mask_s[idx_s] = 1'b1;
      if (&mask_s) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = mask_s;
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cidx_q      <= '0;
      cseg_q      <= 7'h00;
      digits_q    <= '0;
      valid_q     <= '0;
      seen_q      <= '0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cidx_q      <= cidx_d;
      cseg_q      <= cseg_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.err         = err_q;
  assign bus.err_digit   = err_digit_q;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Table-driven bench for ssd_scan_decoder: STABLE_CNT=3 main instance and a
// STABLE_CNT=1 instance, checked through an expected-value queue.
module tb_ssd_scan_decoder;
  logic clk;
  logic rst_n;

  ssd_scan_decoder_if #(.DIGITS(4)) if0 ();
  ssd_scan_decoder_if #(.DIGITS(4)) if1 ();

  ssd_scan_decoder #(.DIGITS(4), .STABLE_CNT(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  ssd_scan_decoder #(.DIGITS(4), .STABLE_CNT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] dig;
    logic [3:0]  val;
    logic        frm;
    logic        err;
    logic [1:0]  ed;
  } vec_t;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  val;
    logic        frm;
    logic        err;
    logic [1:0]  ed;
  } exp_t;

  vec_t tbl0[$];
  vec_t tbl1[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic r, logic e, logic [3:0] a, logic [6:0] s,
                              logic [15:0] d, logic [3:0] v, logic f, logic er, logic [1:0] ed);
    vec_t t;
    t.rst = r; t.en = e; t.an = a; t.seg = s;
    t.dig = d; t.val = v; t.frm = f; t.err = er; t.ed = ed;
    return t;
  endfunction

  task automatic apply(input bit sel, input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n = v.rst;
    if (sel) begin
      if1.sample_en = v.en; if1.an = v.an; if1.seg = v.seg;
      if0.sample_en = 1'b0;
    end else begin
      if0.sample_en = v.en; if0.an = v.an; if0.seg = v.seg;
      if1.sample_en = 1'b0;
    end
    sb.push_back('{v.dig, v.val, v.frm, v.err, v.ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel) g = '{if1.digits_out, if1.digit_valid, if1.frame_valid, if1.err, if1.err_digit};
    else     g = '{if0.digits_out, if0.digit_valid, if0.frame_valid, if0.err, if0.err_digit};
    n_vec++;
    if (g !== e) begin
      n_miss++;
      $display("FAIL dut%0d vec%0d: got dig=%h val=%h frm=%b err=%b ed=%0d, want dig=%h val=%h frm=%b err=%b ed=%0d",
               sel, idx, g.dig, g.val, g.frm, g.err, g.ed, e.dig, e.val, e.frm, e.err, e.ed);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if0.sample_en = 1'b0; if0.an = 4'hF; if0.seg = 7'h7F;
    if1.sample_en = 1'b0; if1.an = 4'hF; if1.seg = 7'h7F;

    // reset, then scan 1,2,3,4 into digits 0..3
    tbl0.push_back(mk(1'b0, 1'b0, 4'hF, 7'h7F, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'h0001, 4'h1, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hD, 7'h24, 16'h0001, 4'h1, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hD, 7'h24, 16'h0001, 4'h1, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hD, 7'h24, 16'h0021, 4'h3, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h30, 16'h0021, 4'h3, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h30, 16'h0021, 4'h3, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h30, 16'h0321, 4'h7, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'h7, 7'h19, 16'h0321, 4'h7, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'h7, 7'h19, 16'h0321, 4'h7, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'h7, 7'h19, 16'h4321, 4'hF, 1'b1, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b0, 4'hF, 7'h7F, 16'h4321, 4'hF, 1'b0, 1'b0, 2'd0));
    // digit 1 toggling 5/6 never settles
    for (int i = 0; i < 4; i++)
      tbl0.push_back(mk(1'b1, 1'b1, 4'hD, (i % 2 == 0) ? 7'h12 : 7'h02, 16'h4321, 4'hF, 1'b0, 1'b0, 2'd0));
    // blank on digit 2, then illegal 7E
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h7F, 16'h4321, 4'hF, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h7F, 16'h4321, 4'hF, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h7F, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h7E, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h7E, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hB, 7'h7E, 16'h4021, 4'hB, 1'b0, 1'b1, 2'd2));
    // multi-enable fault, then idle gap
    tbl0.push_back(mk(1'b1, 1'b1, 4'h3, 7'h79, 16'h4021, 4'hB, 1'b0, 1'b1, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hF, 7'h7F, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    // idle gap clears the count; sample_en gaps do not
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h46, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h46, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hF, 7'h7F, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h46, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b0, 4'hE, 7'h46, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h46, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b0, 4'hE, 7'h46, 16'h4021, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h46, 16'h402C, 4'hB, 1'b0, 1'b0, 2'd2));
    for (int i = 0; i < 6; i++)
      tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h46, 16'h402C, 4'hB, 1'b0, 1'b0, 2'd2));
    // complete the second frame with digits 1 and 3
    tbl0.push_back(mk(1'b1, 1'b1, 4'hD, 7'h30, 16'h402C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hD, 7'h30, 16'h402C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hD, 7'h30, 16'h403C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'h7, 7'h08, 16'h403C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'h7, 7'h08, 16'h403C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'h7, 7'h08, 16'hA03C, 4'hB, 1'b1, 1'b0, 2'd2));
    // reset after two matching strobes discards the partial count
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'hA03C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'hA03C, 4'hB, 1'b0, 1'b0, 2'd2));
    tbl0.push_back(mk(1'b0, 1'b0, 4'hF, 7'h7F, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl0.push_back(mk(1'b1, 1'b0, 4'hE, 7'h79, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0));

    // STABLE_CNT=1: every change commits, repeats do not
    tbl1.push_back(mk(1'b1, 1'b1, 4'hD, 7'h12, 16'h0050, 4'h2, 1'b0, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b1, 4'hD, 7'h02, 16'h0060, 4'h2, 1'b0, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b1, 4'hD, 7'h12, 16'h0050, 4'h2, 1'b0, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b1, 4'hD, 7'h12, 16'h0050, 4'h2, 1'b0, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b1, 4'hE, 7'h79, 16'h0051, 4'h3, 1'b0, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b1, 4'hB, 7'h30, 16'h0351, 4'h7, 1'b0, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b1, 4'h7, 7'h19, 16'h4351, 4'hF, 1'b1, 1'b0, 2'd0));
    tbl1.push_back(mk(1'b1, 1'b0, 4'hF, 7'h7F, 16'h4351, 4'hF, 1'b0, 1'b0, 2'd0));

    for (int i = 0; i < tbl0.size(); i++) apply(1'b0, i, tbl0[i]);
    for (int i = 0; i < tbl1.size(); i++) apply(1'b1, i, tbl1[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the team's hex-to-seven-segment encoder.
- Samples a multiplexed, active-low 4-digit display bus (digit enables plus shared segment bus) and debounces each digit pattern.
- Decodes each stable pattern back to a hex nibble, assembles a multi-digit value and flags frames and illegal patterns.
- Used by display-loopback benches and on-board self-check logic.

Parameters:
DIGITS, 4, number of multiplexed digits; also the width of `an`.
STABLE_CNT, 3, number of consecutive identical qualified samples before a digit commits; legal range 1..15.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
sample_en  input  1  sample strobe; the inputs are examined only in cycles where it is 1.
an  input  DIGITS  active-low digit enables; bit i low selects digit i.
seg  input  7  active-low segments; bit0=a … bit6=g.
digits_out  output  4*DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
digit_valid  output  DIGITS  1 = digit i holds a legal decoded value.
frame_valid  output  1  one-cycle pulse when every digit has committed since the last pulse.
err  output  1  one-cycle pulse on an illegal pattern or multi-enable `an`.
err_digit  output  clog2(DIGITS)  digit index of the last illegal-pattern error; holds until the next one.

Behaviour:
- Reset: applied when rst_n=0 at a clk edge.
  - All outputs 0.
  - Stability counter 0, seen-mask 0, FSM in IDLE.
  - Reset mid-operation discards any partially tracked pattern.
- Decode table (seg -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7.
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
  - 7F = blank.
  - Any other code is illegal.
- Qualified sample: sample_en=1 and exactly one `an` bit low. The selected index and seg form the candidate.
  - `an` all high while sample_en=1: idle gap. FSM goes to IDLE, counter clears, no err.
  - More than one `an` bit low while sample_en=1: err pulses, FSM goes to IDLE, counter clears, no commit. err_digit is unchanged.
- FSM states:
  - IDLE: no tracked candidate.
    - Qualified sample: latch the candidate, counter=1, go to TRACK.
    - If STABLE_CNT=1, commit immediately and go to HELD.
  - TRACK: counter below STABLE_CNT.
    - Qualified sample equal to the latched candidate: counter+1. On reaching STABLE_CNT, commit and go to HELD.
    - Qualified sample that differs: latch the new candidate, counter=1, stay in TRACK.
  - HELD: candidate already committed.
    - Equal sample: no action; each digit commits only once per stable period.
    - Differing qualified sample: treated as in IDLE.
  - sample_en=0: all state holds.
- Commit for digit i (registered; outputs change at the clk edge after the STABLE_CNT-th matching sample's cycle, i.e. 1-cycle latency):
  - Legal code: the nibble is written to slot i; digit_valid[i]=1.
  - Blank: slot i=0; digit_valid[i]=0; no err.
  - Illegal code: slot i is unchanged; digit_valid[i]=0; err pulses; err_digit=i.
  - Every commit sets seen-mask bit i.
- Frame: when the seen-mask becomes all-ones, frame_valid pulses in the cycle the final commit appears and the mask clears in the same edge.
  - A same-cycle commit to an already-seen digit does not re-set the cleared bit; it is counted toward the next frame only if it is that frame's commit.
- Error priority: if an illegal commit and a multi-enable fault cannot coincide (one sample per cycle), err is a single pulse per event.
- Counter width: 4 bits; it saturates at STABLE_CNT and never wraps.

Test Plan:
- Reset, then scan digits 0..3 with seg 79,24,30,19, each held 3 strobes -> digits_out=16'h4321, digit_valid=4'hF, and exactly one frame_valid pulse one cycle after digit 3's third strobe.
- Digit 1 pattern 12 toggling with 02 every strobe -> no commit; digits_out unchanged; STABLE_CNT=1 variant commits on every change.
- Digit 2 held at seg=7F -> slot 2=0, digit_valid[2]=0, no err; then seg=7E held 3 strobes -> err pulse, err_digit=2, slot 2 unchanged.
- an=4'b0011 with sample_en=1 -> single err pulse, no commit, err_digit unchanged; an=4'hF -> counter clears, no err.
- Digit 0 held at 46 for 10 strobes -> exactly one commit (nibble C); sample_en=0 gaps inside the hold do not break the count.
- Assert rst_n=0 after 2 of 3 matching strobes -> all outputs 0; the next single strobe after release does not commit.
